// File: rtl/ipr_write_buffer.sv
// Posted-write buffer: acknowledges router writes immediately, queues them and
// replays them to the neighbour memory port. Optional perf counters: IPR_WBUF_PERF_EN.
module ipr_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          slv_req_i,
    input  logic [ADDR_WIDTH-1:0]         slv_addr_i,
    input  logic [DATA_WIDTH-1:0]         slv_wdata_i,
    input  logic                          slv_we_i,
    input  logic [DATA_WIDTH/8-1:0]       slv_be_i,
    output logic                          slv_gnt_o,
    output logic                          slv_rvalid_o,
    output logic [DATA_WIDTH-1:0]         slv_rdata_o,
    output logic                          mst_req_o,
    output logic [ADDR_WIDTH-1:0]         mst_addr_o,
    output logic [DATA_WIDTH-1:0]         mst_wdata_o,
    output logic                          mst_we_o,
    output logic [DATA_WIDTH/8-1:0]       mst_be_o,
    input  logic                          mst_gnt_i,
    input  logic                          mst_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         mst_rdata_i,
    output logic                          empty_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic [7:0]                    rd_err_cnt_o
`ifdef IPR_WBUF_PERF_EN
    ,
    output logic [15:0]                   perf_wr_cnt_o,
    output logic [15:0]                   perf_stall_cnt_o
`endif
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = 3;
    localparam logic [DATA_WIDTH-1:0] RD_ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [BE_W-1:0]       be_mem_q   [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [OUT_W-1:0]      outst_q, outst_d;
    logic [7:0]            rd_err_q, rd_err_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  full_s, accept_s, push_s, pop_s, req_s, rv_s;
    logic                  unused_rdata_s;

    // Grant depends only on the request and the registered count, so no mst_* input reaches slv_*.
    assign full_s   = (count_q == CNT_W'(DEPTH));
    assign accept_s = slv_req_i & ~full_s;
    assign push_s   = accept_s & slv_we_i;
    assign req_s    = (count_q != {CNT_W{1'b0}}) & (outst_q < OUT_W'(MAX_OUTST));
    assign pop_s    = req_s & mst_gnt_i;
    assign rv_s     = mst_rvalid_i & (outst_q != {OUT_W{1'b0}});
    assign unused_rdata_s = ^mst_rdata_i;

    assign slv_gnt_o    = accept_s;
    assign slv_rvalid_o = rvalid_q;
    assign slv_rdata_o  = rdata_q;
    assign mst_req_o    = req_s;
    assign mst_addr_o   = addr_mem_q[rd_ptr_q];
    assign mst_wdata_o  = data_mem_q[rd_ptr_q];
    assign mst_be_o     = be_mem_q[rd_ptr_q];
    assign mst_we_o     = 1'b1;
    assign empty_o      = (count_q == {CNT_W{1'b0}});
    assign count_o      = count_q;
    assign rd_err_cnt_o = rd_err_q;

    // Next-state for pointers, occupancy, outstanding responses and the posted reply.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        outst_d  = outst_q;
        rd_err_d = rd_err_q;
        rvalid_d = accept_s;
        rdata_d  = {DATA_WIDTH{1'b0}};
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case ({pop_s, rv_s})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase
        if (accept_s & ~slv_we_i) begin
            rdata_d = RD_ERR_DATA;
            if (rd_err_q != 8'hFF) begin
                rd_err_d = rd_err_q + 8'd1;
            end else begin
                rd_err_d = rd_err_q;
            end
        end else begin
            rdata_d  = {DATA_WIDTH{1'b0}};
            rd_err_d = rd_err_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            outst_q  <= {OUT_W{1'b0}};
            rd_err_q <= 8'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            rd_err_q <= rd_err_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Entry storage; cleared on reset so the head outputs read as zero afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= {ADDR_WIDTH{1'b0}};
                data_mem_q[i] <= {DATA_WIDTH{1'b0}};
                be_mem_q[i]   <= {BE_W{1'b0}};
            end
        end else if (push_s) begin
            addr_mem_q[wr_ptr_q] <= slv_addr_i;
            data_mem_q[wr_ptr_q] <= slv_wdata_i;
            be_mem_q[wr_ptr_q]   <= slv_be_i;
        end else begin
            addr_mem_q[wr_ptr_q] <= addr_mem_q[wr_ptr_q];
        end
    end

`ifdef IPR_WBUF_PERF_EN
    logic [15:0] perf_wr_q, perf_stall_q;
    assign perf_wr_cnt_o    = perf_wr_q;
    assign perf_stall_cnt_o = perf_stall_q;

    // Saturating counters of accepted writes and downstream stall cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_wr_q    <= 16'd0;
            perf_stall_q <= 16'd0;
        end else begin
            if (push_s && (perf_wr_q != 16'hFFFF)) begin
                perf_wr_q <= perf_wr_q + 16'd1;
            end else begin
                perf_wr_q <= perf_wr_q;
            end
            if (req_s && !mst_gnt_i && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end else begin
                perf_stall_q <= perf_stall_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ipr_write_buffer.sv
// Self-checking bench for ipr_write_buffer: vector table plus hand sequences,
// with a negedge scoreboard modelling occupancy, outstanding count and data order.
module tb_ipr_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slv_req_i = 1'b0;
    logic [31:0] slv_addr_i = 32'd0;
    logic [31:0] slv_wdata_i = 32'd0;
    logic        slv_we_i = 1'b0;
    logic [3:0]  slv_be_i = 4'd0;
    logic        slv_gnt_o, slv_rvalid_o, mst_req_o, mst_we_o, empty_o;
    logic [31:0] slv_rdata_o, mst_addr_o, mst_wdata_o;
    logic [3:0]  mst_be_o;
    logic        mst_gnt_i = 1'b0;
    logic        mst_rvalid_i = 1'b0;
    logic [31:0] mst_rdata_i = 32'd0;
    logic [2:0]  count_o;
    logic [7:0]  rd_err_cnt_o;
`ifdef IPR_WBUF_PERF_EN
    logic [15:0] perf_wr_cnt_o, perf_stall_cnt_o;
`endif

    ipr_write_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTST(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_req_i(slv_req_i), .slv_addr_i(slv_addr_i), .slv_wdata_i(slv_wdata_i),
        .slv_we_i(slv_we_i), .slv_be_i(slv_be_i), .slv_gnt_o(slv_gnt_o),
        .slv_rvalid_o(slv_rvalid_o), .slv_rdata_o(slv_rdata_o),
        .mst_req_o(mst_req_o), .mst_addr_o(mst_addr_o), .mst_wdata_o(mst_wdata_o),
        .mst_we_o(mst_we_o), .mst_be_o(mst_be_o), .mst_gnt_i(mst_gnt_i),
        .mst_rvalid_i(mst_rvalid_i), .mst_rdata_i(mst_rdata_i),
        .empty_o(empty_o), .count_o(count_o), .rd_err_cnt_o(rd_err_cnt_o)
`ifdef IPR_WBUF_PERF_EN
        , .perf_wr_cnt_o(perf_wr_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit tog_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } ent_t;

    ent_t        dq[$];
    logic [31:0] rq[$];
    int          m_cnt = 0, m_outst = 0, m_err = 0;
    bit          prev_acc = 1'b0, prev_hold = 1'b0;
    ent_t        held;

    always @(negedge clk) begin
        ent_t e;
        bit   acc, push, pop, mreq, rv_eff;
        if (!rst_n) begin
            dq.delete();
            rq.delete();
            m_cnt = 0; m_outst = 0; m_err = 0;
            prev_acc = 1'b0; prev_hold = 1'b0;
        end else begin
            mreq = (m_cnt != 0) && (m_outst < 2);
            acc  = slv_req_i && (m_cnt != 4);
            chk("count", count_o, m_cnt);
            chk("empty", empty_o, m_cnt == 0);
            chk("slv_gnt", slv_gnt_o, acc);
            chk("mst_req", mst_req_o, mreq);
            chk("mst_we", mst_we_o, 1'b1);
            chk("rd_err_cnt", rd_err_cnt_o, m_err);
            chk("slv_rvalid", slv_rvalid_o, prev_acc);
            if (slv_rvalid_o) begin
                chk("resp_pending", rq.size() > 0, 1'b1);
                if (rq.size() > 0) chk("slv_rdata", slv_rdata_o, rq.pop_front());
            end
            if (prev_hold && mst_req_o) begin
                chk("hold_addr", mst_addr_o, held.a);
                chk("hold_wdata", mst_wdata_o, held.d);
                chk("hold_be", mst_be_o, held.b);
            end
            push   = acc && slv_we_i;
            pop    = mreq && mst_gnt_i;
            rv_eff = mst_rvalid_i && (m_outst != 0);
            if (pop) begin
                chk("pop_pending", dq.size() > 0, 1'b1);
                if (dq.size() > 0) begin
                    e = dq.pop_front();
                    chk("mst_addr", mst_addr_o, e.a);
                    chk("mst_wdata", mst_wdata_o, e.d);
                    chk("mst_be", mst_be_o, e.b);
                end
            end
            if (acc) rq.push_back(slv_we_i ? 32'h0 : 32'hDEAD_BEEF);
            if (push) dq.push_back('{a: slv_addr_i, d: slv_wdata_i, b: slv_be_i});
            if (acc && !slv_we_i && m_err < 255) m_err++;
            m_cnt = m_cnt + int'(push) - int'(pop);
            if (pop && !rv_eff) m_outst++;
            else if (!pop && rv_eff) m_outst--;
            prev_acc  = acc;
            prev_hold = mreq && !mst_gnt_i;
            held      = '{a: mst_addr_o, d: mst_wdata_o, b: mst_be_o};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        if (tog_en) mst_gnt_i = ~mst_gnt_i;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        bit got;
        got = 1'b0;
        slv_req_i = 1'b1; slv_we_i = 1'b1;
        slv_addr_i = a; slv_wdata_i = d; slv_be_i = b;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (slv_gnt_o) begin
                got = 1'b1;
                break;
            end
            cyc();
        end
        if (!got) chk("wr_timeout", got, 1'b1);
        cyc();
        slv_req_i = 1'b0; slv_we_i = 1'b0;
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        mgnt;
        logic        mrv;
        logic        exp_sgnt;
        logic        exp_mreq;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t vt[18];

    // ---------------- main sequence ----------------
    initial begin
        // single write, fill, outstanding limit
        vt[0]  = '{1'b1, 1'b1, 32'h1000_0010, 32'hA5A5_0001, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0};
        vt[1]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1};
        vt[2]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vt[3]  = '{1'b1, 1'b1, 32'h2000_0000, 32'hB000_0000, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
        vt[4]  = '{1'b1, 1'b1, 32'h2000_0004, 32'hB000_0001, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1};
        vt[5]  = '{1'b1, 1'b1, 32'h2000_0008, 32'hB000_0002, 4'hC, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2};
        vt[6]  = '{1'b1, 1'b1, 32'h2000_000C, 32'hB000_0003, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3};
        vt[7]  = '{1'b1, 1'b1, 32'h2000_0010, 32'hB000_0004, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4};
        vt[8]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4};
        vt[9]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4};
        vt[10] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3};
        vt[11] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2};
        vt[12] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2};
        vt[13] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2};
        vt[14] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
        vt[15] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1};
        vt[16] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
        vt[17] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};

        #2;
        chk("rst_rvalid", slv_rvalid_o, 1'b0);
        chk("rst_rdata", slv_rdata_o, 32'h0);
        chk("rst_mst_req", mst_req_o, 1'b0);
        chk("rst_mst_addr", mst_addr_o, 32'h0);
        chk("rst_mst_wdata", mst_wdata_o, 32'h0);
        chk("rst_mst_be", mst_be_o, 4'h0);
        chk("rst_mst_we", mst_we_o, 1'b1);
        chk("rst_empty", empty_o, 1'b1);
        chk("rst_count", count_o, 3'd0);
        chk("rst_rd_err", rd_err_cnt_o, 8'd0);
        cyc();
        cyc();
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            slv_req_i = vt[i].req; slv_we_i = vt[i].we;
            slv_addr_i = vt[i].addr; slv_wdata_i = vt[i].wdata; slv_be_i = vt[i].be;
            mst_gnt_i = vt[i].mgnt; mst_rvalid_i = vt[i].mrv;
            #1;
            chk($sformatf("vec%0d_slv_gnt", i), slv_gnt_o, vt[i].exp_sgnt);
            chk($sformatf("vec%0d_mst_req", i), mst_req_o, vt[i].exp_mreq);
            chk($sformatf("vec%0d_count", i), count_o, vt[i].exp_cnt);
            if (i == 8) chk("fill_head_addr", mst_addr_o, 32'h2000_0000);
            cyc();
        end
        slv_req_i = 1'b0; mst_gnt_i = 1'b0; mst_rvalid_i = 1'b0;

        // rejected read, then saturation
        slv_req_i = 1'b1; slv_we_i = 1'b0; slv_addr_i = 32'h20;
        #1;
        chk("rd_gnt", slv_gnt_o, 1'b1);
        cyc();
        slv_req_i = 1'b0;
        #1;
        chk("rd_rvalid", slv_rvalid_o, 1'b1);
        chk("rd_rdata", slv_rdata_o, 32'hDEAD_BEEF);
        chk("rd_err_one", rd_err_cnt_o, 8'd1);
        chk("rd_no_push", count_o, 3'd0);
        slv_req_i = 1'b1;
        for (int n = 0; n < 300; n++) cyc();
        slv_req_i = 1'b0;
        cyc();
        cyc();
        chk("rd_err_sat", rd_err_cnt_o, 8'd255);

        // wrap-around with toggling downstream grant
        mst_rvalid_i = 1'b1;
        tog_en = 1'b1;
        for (int k = 0; k < 10; k++)
            wr(32'h3000_0000 + 32'(k * 4), 32'hC0DE_0000 + 32'(k), 4'(k + 1));
        for (int n = 0; n < 100; n++) begin
            if (empty_o && dq.size() == 0) break;
            cyc();
        end
        chk("wrap_drained", empty_o, 1'b1);
        chk("wrap_sb_empty", dq.size(), 0);
        tog_en = 1'b0; mst_gnt_i = 1'b0;
        cyc();
        cyc();
        mst_rvalid_i = 1'b0;

        // reset mid-operation: 3 queued, 1 outstanding
        for (int k = 0; k < 4; k++)
            wr(32'h4000_0000 + 32'(k * 4), 32'hD000_0000 + 32'(k), 4'hF);
        mst_gnt_i = 1'b1;
        cyc();
        mst_gnt_i = 1'b0;
        chk("pre_rst_count", count_o, 3'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_empty", empty_o, 1'b1);
        chk("mid_rst_mst_req", mst_req_o, 1'b0);
        chk("mid_rst_count", count_o, 3'd0);
        chk("mid_rst_addr", mst_addr_o, 32'h0);
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        mst_gnt_i = 1'b1;
        wr(32'h5000_0000, 32'hE000_0001, 4'h6);
        #1;
        chk("post_rst_req", mst_req_o, 1'b1);
        chk("post_rst_addr", mst_addr_o, 32'h5000_0000);
        cyc();
        mst_gnt_i = 1'b0;
        mst_rvalid_i = 1'b1;
        cyc();
        mst_rvalid_i = 1'b0;
        cyc();
        chk("end_sb_empty", dq.size(), 0);
        chk("end_empty", empty_o, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
